blk_mem_responder: RTL and testbench
====================================

// Module: blk_mem_responder
// PURPOSE
//   Memory-side responder for the cache's 4-word block refill/write-back protocol. Accepts one
//   block request per handshake, inserts LATENCY wait states, then streams BEATS words in or out
//   of an internal synchronous RAM. Sits between cache miss logic and main memory; replaces
//   direct single-cycle BRAM access so miss penalty is tunable. Counts served reads/writes.
// PARAMETERS
//   BEATS    4   words per block (power of 2, >=2)
//   LATENCY  4   wait cycles between request accept and first beat (0 allowed)
//   ADDR_W   10  word-address width of internal RAM (2**ADDR_W words)
// PORTS
//   clk        in   1   clock, rising edge
//   rstn       in   1   reset, asynchronous, active-low
//   req_valid  in   1   block request present
//   req_ready  out  1   responder idle, request accepted when req_valid&&req_ready
//   req_we     in   1   1 = write-back block, 0 = refill read
//   req_addr   in   32  byte address; low log2(BEATS*4) bits ignored (block aligned)
//   wdata      in   32  write beat data
//   wvalid     in   1   write beat present
//   wready     out  1   write beat accepted when wvalid&&wready
//   rdata      out  32  read beat data
//   rvalid     out  1   read beat valid (no backpressure; initiator must take every beat)
//   rlast      out  1   with rvalid: final beat of block
//   resp_done  out  1   one-cycle pulse: block transfer complete, responder returns to IDLE next cycle
//   rd_cnt     out  32  completed read blocks
//   wr_cnt     out  32  completed write blocks
// BEHAVIOUR
//   Reset: state IDLE; req_ready=1 after release; wready/rvalid/rlast/resp_done=0; rdata=0;
//     rd_cnt=wr_cnt=0; latched addr/we/beat/wait counters cleared; RAM contents NOT cleared.
//   Reset mid-transfer: abort immediately to IDLE, partial writes already committed stay in RAM.
//   FSM: IDLE -> WAIT -> (req_we ? WR : RD) -> DONE -> IDLE.
//   IDLE: req_ready=1; on accept latch base word index = req_addr[ADDR_W+1:2] with low
//     log2(BEATS) bits zeroed, latch req_we; go WAIT (LATENCY>0) else straight to WR/RD.
//   WAIT: count LATENCY cycles exactly (accept cycle not counted); req_ready=wready=0.
//   WR: wready=1; each wvalid cycle writes wdata to base+beat, beat++; wvalid low stalls, no
//     timeout; after beat BEATS-1 accepted -> DONE. Beat order strictly ascending from 0.
//   RD: issue RAM read base+beat each cycle, beat 0..BEATS-1 on consecutive cycles; RAM read
//     latency 1, so rvalid high for BEATS consecutive cycles starting cycle after first issue;
//     rlast on final beat; state moves to DONE the cycle rlast is driven.
//   DONE: resp_done=1 one cycle; rd_cnt or wr_cnt +1 (32-bit wrap); -> IDLE.
//   Read-block latency: accept at cycle 0 -> first rvalid at cycle LATENCY+2, resp_done at
//     LATENCY+BEATS+2. Write with continuous wvalid: resp_done at LATENCY+BEATS+1.
//   req_valid while not IDLE ignored (req_ready=0); wvalid outside WR ignored (wready=0).
//   Address wrap: word index taken modulo 2**ADDR_W; upper req_addr bits ignored.
//   Read-after-write to same block in back-to-back requests returns new data (no bypass needed,
//     writes complete before DONE).
// STRUCTURE
//   Shared package: state encoding (IDLE/WAIT/WR/RD/DONE), BEAT_W=$clog2(BEATS),
//     OFF_W=$clog2(BEATS*4), LAT_W=$clog2(LATENCY+1) helper constants.
//   Sub-module: sp_ram (single-port, sync read 1-cycle, sync write, WIDTH=32, DEPTH=2**ADDR_W).
//   Counters/registers via existing enable-register primitive; FSM and beat/wait counters local.
// TESTING
//   1 Reset mid-RD (assert rstn=0 at 2nd rvalid) -> all outputs 0 immediately, req_ready=1 after.
//   2 Write blk 0x40 words A0..A3, LATENCY=4, wvalid continuous -> resp_done cycle 9, wr_cnt=1.
//   3 Read 0x4C (unaligned) -> rvalid cycles 6..9 data A0,A1,A2,A3, rlast at cycle 9, rd_cnt=1.
//   4 Write with wvalid gap of 3 cycles after beat 1 -> RAM holds all 4 words, done delayed 3.
//   5 req_valid held during busy transfer -> only one request served; second accepted after done.
//   6 LATENCY=0 build, addr 0x1000 (ADDR_W=10) -> aliases word 0; read-back equals prior write.

Source files
------------

// File: rtl/blk_mem_responder_pkg.sv
// Shared types and width helpers for the block memory responder.
package blk_mem_responder_pkg;

  localparam int DATA_W      = 32;
  localparam int DEF_BEATS   = 4;
  localparam int DEF_LATENCY = 4;
  localparam int DEF_ADDR_W  = 10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_WR   = 3'd2,
    ST_RD   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Bits needed to index a beat within a block.
  function automatic int beat_w(input int beats);
    return $clog2(beats);
  endfunction

  // Byte-offset bits covered by one block.
  function automatic int off_w(input int beats);
    return $clog2(beats * 4);
  endfunction

  // Wait counter width; kept at least 1 so a zero-latency build still elaborates.
  function automatic int lat_w(input int latency);
    return (latency < 1) ? 1 : $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/blk_mem_responder_if.sv
// Request / write-beat / read-beat bundle between the cache miss logic and the responder.
interface blk_mem_responder_if import blk_mem_responder_pkg::*; ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] wdata;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              rlast;
  logic              resp_done;

  // Cache side: issues block requests and write beats, consumes read beats.
  modport master (
    output req_valid, req_we, req_addr, wdata, wvalid,
    input  req_ready, wready, rdata, rvalid, rlast, resp_done
  );

  // Memory side: the responder.
  modport slave (
    input  req_valid, req_we, req_addr, wdata, wvalid,
    output req_ready, wready, rdata, rvalid, rlast, resp_done
  );

endinterface

// File: rtl/blk_mem_responder_sp_ram.sv
// Single-port RAM: synchronous write, synchronous read with one cycle of latency.
module blk_mem_responder_sp_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write or read one word per enabled cycle.
  // NOTE: no reset here; a reset cannot clear a block RAM array, and adding one would stop it mapping to RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/blk_mem_responder.sv
// Memory-side responder for block refill / write-back: accept a request, wait LATENCY
// cycles, then stream BEATS words into or out of the internal RAM.
module blk_mem_responder import blk_mem_responder_pkg::*; #(
  parameter int BEATS   = DEF_BEATS,
  parameter int LATENCY = DEF_LATENCY,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rstn,
  blk_mem_responder_if.slave bus,
  output logic [DATA_W-1:0] rd_cnt,
  output logic [DATA_W-1:0] wr_cnt
);

  localparam int BEAT_W = beat_w(BEATS);
  localparam int OFF_W  = off_w(BEATS);
  localparam int LAT_W  = lat_w(LATENCY);
  localparam int BLK_W  = ADDR_W - BEAT_W;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [LAT_W-1:0]  WAIT_LAST = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  state_t            state_q, state_d;
  logic [BLK_W-1:0]  blk_q;
  logic              we_q;
  logic [BEAT_W:0]   beat_q;      // extra top bit marks "all read beats issued"
  logic [LAT_W-1:0]  wait_q;
  logic              ready_q;
  logic              rvalid_q;
  logic              rlast_q;

  logic              accept;
  logic              wr_beat;
  logic              rd_issue;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_q;
  logic              unused_addr_bits;

  assign accept   = (state_q == ST_IDLE) && bus.req_valid && ready_q;
  assign wr_beat  = (state_q == ST_WR) && bus.wvalid;
  assign rd_issue = (state_q == ST_RD) && !beat_q[BEAT_W];
  assign ram_addr = {blk_q, beat_q[BEAT_W-1:0]};

  // Byte offset within the block and address bits above the RAM are don't-care.
  assign unused_addr_bits = ^{bus.req_addr[DATA_W-1:ADDR_W+2], bus.req_addr[OFF_W-1:0]};

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = (LATENCY > 0) ? ST_WAIT : (bus.req_we ? ST_WR : ST_RD);
      ST_WAIT: if (wait_q == WAIT_LAST) state_d = we_q ? ST_WR : ST_RD;
      ST_WR:   if (wr_beat && (beat_q[BEAT_W-1:0] == LAST_BEAT)) state_d = ST_DONE;
      ST_RD:   if (rlast_q) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state and the registered read-beat flags.
  always_comb begin
    bus.req_ready = ready_q;
    bus.wready    = (state_q == ST_WR);
    bus.resp_done = (state_q == ST_DONE);
    bus.rvalid    = rvalid_q;
    bus.rlast     = rlast_q;
    bus.rdata     = rvalid_q ? ram_q : '0;
  end

  // Latch block index and direction on request accept.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      blk_q <= '0;
      we_q  <= 1'b0;
    end else if (accept) begin
      blk_q <= bus.req_addr[ADDR_W+1:OFF_W];
      we_q  <= bus.req_we;
    end
  end

  // Wait-state counter and beat counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_q <= '0;
      beat_q <= '0;
    end else begin
      wait_q <= (state_q == ST_WAIT) ? wait_q + 1'b1 : '0;
      if (wr_beat || rd_issue)                      beat_q <= beat_q + 1'b1;
      else if (state_q != ST_WR && state_q != ST_RD) beat_q <= '0;
    end
  end

  // Read beat flags track the RAM's one-cycle read latency; ready follows the next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      rvalid_q <= rd_issue;
      rlast_q  <= rd_issue && (beat_q[BEAT_W-1:0] == LAST_BEAT);
      ready_q  <= (state_d == ST_IDLE);
    end
  end

  // Completed-block counters, bumped once per DONE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (state_q == ST_DONE) begin
      if (we_q) wr_cnt <= wr_cnt + 1'b1;
      else      rd_cnt <= rd_cnt + 1'b1;
    end
  end

  blk_mem_responder_sp_ram #(
    .WIDTH (DATA_W),
    .DEPTH (2 ** ADDR_W)
  ) u_ram (
    .clk   (clk),
    .en    (wr_beat || rd_issue),
    .we    (wr_beat),
    .addr  (ram_addr),
    .wdata (bus.wdata),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_blk_mem_responder.sv
// Directed bench for blk_mem_responder: a LATENCY=4 instance and a LATENCY=0 instance
// share one stimulus bus, selected by sel.
module tb_blk_mem_responder;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        sel = 1'b0;        // 0: LATENCY=4 instance, 1: LATENCY=0 instance
  int          lat = 4;           // latency of the selected instance
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] wdata = '0;
  logic        wvalid = 1'b0;

  logic [31:0] rd_cnt4, wr_cnt4, rd_cnt0, wr_cnt0;

  logic        o_ready, o_wready, o_rvalid, o_rlast, o_done;
  logic [31:0] o_rdata, o_rdcnt, o_wrcnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  blk_mem_responder_if bus4 ();
  blk_mem_responder_if bus0 ();

  assign bus4.req_valid = req_valid & ~sel;
  assign bus4.req_we    = req_we;
  assign bus4.req_addr  = req_addr;
  assign bus4.wdata     = wdata;
  assign bus4.wvalid    = wvalid;
  assign bus0.req_valid = req_valid & sel;
  assign bus0.req_we    = req_we;
  assign bus0.req_addr  = req_addr;
  assign bus0.wdata     = wdata;
  assign bus0.wvalid    = wvalid;

  assign o_ready  = sel ? bus0.req_ready : bus4.req_ready;
  assign o_wready = sel ? bus0.wready    : bus4.wready;
  assign o_rvalid = sel ? bus0.rvalid    : bus4.rvalid;
  assign o_rlast  = sel ? bus0.rlast     : bus4.rlast;
  assign o_done   = sel ? bus0.resp_done : bus4.resp_done;
  assign o_rdata  = sel ? bus0.rdata     : bus4.rdata;
  assign o_rdcnt  = sel ? rd_cnt0        : rd_cnt4;
  assign o_wrcnt  = sel ? wr_cnt0        : wr_cnt4;

  blk_mem_responder #(.BEATS(4), .LATENCY(4), .ADDR_W(10)) dut4 (
    .clk(clk), .rstn(rstn), .bus(bus4), .rd_cnt(rd_cnt4), .wr_cnt(wr_cnt4)
  );

  blk_mem_responder #(.BEATS(4), .LATENCY(0), .ADDR_W(10)) dut0 (
    .clk(clk), .rstn(rstn), .bus(bus0), .rd_cnt(rd_cnt0), .wr_cnt(wr_cnt0)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] dbase;     // beat i carries dbase + i (written or expected)
    int          gap;       // wvalid-low cycles after beat 1 (writes only)
    int          exp_done;  // resp_done cycle, accept = cycle 0
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until the edge that accepts it; returns observing cycle 1.
  task automatic accept_req(input logic we, input logic [31:0] addr);
    int n = 0;
    req_we = we;
    req_addr = addr;
    req_valid = 1'b1;
    while (!o_ready && n < 20) begin
      tick();
      n++;
    end
    check("req_ready_at_accept", 32'(o_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  // One cycle past resp_done: pulse gone, responder idle again.
  task automatic finish_xfer(input string tag);
    tick();
    check($sformatf("%s_done_pulse", tag), 32'(o_done), 32'd0);
    check($sformatf("%s_ready_back", tag), 32'(o_ready), 32'd1);
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] dbase,
                          input int gap_len, input int exp_done);
    int   beat = 0;
    int   gap = 0;
    int   cyc = 1;
    int   done = -1;
    logic acc;
    wvalid = 1'b1;
    wdata = 32'hDEAD_BEEF;      // offered before WR; must not be written
    accept_req(1'b1, addr);
    while (cyc < 60) begin
      if (o_done) begin
        done = cyc;
        break;
      end
      if (gap > 0) begin
        wvalid = 1'b0;
        gap--;
      end else if (beat < 4) begin
        wvalid = 1'b1;
        wdata = dbase + 32'(beat);
      end else begin
        wvalid = 1'b0;
      end
      acc = wvalid && o_wready;
      tick();
      cyc++;
      if (acc) begin
        beat++;
        if (beat == 2) gap = gap_len;
      end
    end
    wvalid = 1'b0;
    check($sformatf("%s_done_cycle", tag), 32'(done), 32'(exp_done));
    finish_xfer(tag);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp_base,
                         input int exp_done);
    int cyc = 1;
    int n = 0;
    int first = -1;
    int last = -1;
    int done = -1;
    accept_req(1'b0, addr);
    while (cyc < 60) begin
      if (o_rvalid) begin
        if (n == 0) first = cyc;
        if (n < 4) check($sformatf("%s_data%0d", tag, n), o_rdata, exp_base + 32'(n));
        if (o_rlast) last = cyc;
        n++;
      end
      if (o_done) begin
        done = cyc;
        break;
      end
      tick();
      cyc++;
    end
    check($sformatf("%s_first_rvalid", tag), 32'(first), 32'(lat + 2));
    check($sformatf("%s_rlast_cycle", tag), 32'(last), 32'(lat + 5));
    check($sformatf("%s_done_cycle", tag), 32'(done), 32'(exp_done));
    check($sformatf("%s_beats", tag), 32'(n), 32'd4);
    finish_xfer(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[7];
    logic [31:0] mask;
    int          rl;
    int          n;

    vecs[0] = '{we: 1'b1, addr: 32'h0000_0040, dbase: 32'hA000_00A0, gap: 0, exp_done: 9};
    vecs[1] = '{we: 1'b0, addr: 32'h0000_004C, dbase: 32'hA000_00A0, gap: 0, exp_done: 10};
    vecs[2] = '{we: 1'b1, addr: 32'h0000_0080, dbase: 32'hB000_00B0, gap: 3, exp_done: 12};
    vecs[3] = '{we: 1'b0, addr: 32'h0000_0080, dbase: 32'hB000_00B0, gap: 0, exp_done: 10};
    vecs[4] = '{we: 1'b0, addr: 32'h0000_0044, dbase: 32'hA000_00A0, gap: 0, exp_done: 10};
    vecs[5] = '{we: 1'b1, addr: 32'h0000_1040, dbase: 32'hC000_00C0, gap: 0, exp_done: 9};
    vecs[6] = '{we: 1'b0, addr: 32'h0000_0040, dbase: 32'hC000_00C0, gap: 0, exp_done: 10};

    // Reset state.
    #2 rstn = 1'b0;
    tick();
    tick();
    check("rst_req_ready", 32'(o_ready), 32'd0);
    check("rst_wready", 32'(o_wready), 32'd0);
    check("rst_rvalid", 32'(o_rvalid), 32'd0);
    check("rst_rlast", 32'(o_rlast), 32'd0);
    check("rst_rdata", o_rdata, 32'd0);
    check("rst_resp_done", 32'(o_done), 32'd0);
    check("rst_rd_cnt", o_rdcnt, 32'd0);
    check("rst_wr_cnt", o_wrcnt, 32'd0);
    rstn = 1'b1;
    tick();
    check("rel_req_ready", 32'(o_ready), 32'd1);

    // Table of block transfers on the LATENCY=4 instance.
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].we)
        do_write($sformatf("v%0d_wr", i), vecs[i].addr, vecs[i].dbase, vecs[i].gap, vecs[i].exp_done);
      else
        do_read($sformatf("v%0d_rd", i), vecs[i].addr, vecs[i].dbase, vecs[i].exp_done);
    end
    check("tbl_wr_cnt", o_wrcnt, 32'd3);
    check("tbl_rd_cnt", o_rdcnt, 32'd4);

    // Request held through a busy transfer: ready only returns at cycle 11.
    mask = '0;
    rl = 0;
    req_we = 1'b0;
    req_addr = 32'h0000_0080;
    req_valid = 1'b1;
    tick();
    for (int c = 1; c <= 11; c++) begin
      mask[c] = o_ready;
      if (o_rlast) rl++;
      if (c < 11) tick();
    end
    check("busy_ready_mask", mask, 32'h0000_0800);
    check("busy_rlast_count", 32'(rl), 32'd1);
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!o_done && n < 40) begin
      tick();
      n++;
    end
    check("busy_second_done", 32'(o_done), 32'd1);
    tick();
    check("busy_rd_cnt", o_rdcnt, 32'd6);

    // Zero-latency instance; 0x1000 aliases word 0.
    sel = 1'b1;
    lat = 0;
    tick();
    do_write("l0_wr", 32'h0000_1000, 32'hD000_00D0, 0, 5);
    do_read("l0_rd", 32'h0000_0000, 32'hD000_00D0, 6);
    check("l0_wr_cnt", o_wrcnt, 32'd1);
    check("l0_rd_cnt", o_rdcnt, 32'd1);
    sel = 1'b0;
    lat = 4;
    tick();

    // Reset asserted at the second read beat.
    accept_req(1'b0, 32'h0000_0040);
    n = 0;
    for (int c = 0; c < 30; c++) begin
      if (o_rvalid) n++;
      if (n == 2) break;
      tick();
    end
    check("mid_rd_beats_seen", 32'(n), 32'd2);
    rstn = 1'b0;
    #1;
    check("mid_rst_rvalid", 32'(o_rvalid), 32'd0);
    check("mid_rst_rlast", 32'(o_rlast), 32'd0);
    check("mid_rst_rdata", o_rdata, 32'd0);
    check("mid_rst_done", 32'(o_done), 32'd0);
    check("mid_rst_ready", 32'(o_ready), 32'd0);
    check("mid_rst_wready", 32'(o_wready), 32'd0);
    check("mid_rst_rd_cnt", o_rdcnt, 32'd0);
    check("mid_rst_wr_cnt", o_wrcnt, 32'd0);
    tick();
    tick();
    rstn = 1'b1;
    tick();
    check("mid_rel_ready", 32'(o_ready), 32'd1);
    do_read("post_rst_rd", 32'h0000_0040, 32'hC000_00C0, 10);
    check("post_rst_rd_cnt", o_rdcnt, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
